// File: rtl/mem_arbiter.sv
// mem_arbiter: fair two-port arbiter (CPU vs debug) in front of a single-port synchronous-read memory.
// Each access runs grant, optional wait cycles, then a data/ack cycle. Ties alternate between the ports.
module mem_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          CpuReq,
    input  logic          CpuWE,
    input  logic [AW-1:0] CpuAdr,
    input  logic [DW-1:0] CpuWD,
    output logic [DW-1:0] CpuRD,
    output logic          CpuReady,
    input  logic          DbgReq,
    input  logic          DbgWE,
    input  logic [AW-1:0] DbgAdr,
    input  logic [DW-1:0] DbgWD,
    output logic [DW-1:0] DbgRD,
    output logic          DbgAck,
    output logic [AW-1:0] MemAdr,
    output logic          MemWE,
    output logic [DW-1:0] MemWD,
    input  logic [DW-1:0] MemRD,
    output logic          Busy
);
    typedef enum logic [2:0] {IDLE, G_CPU, W_CPU, D_CPU, G_DBG, W_DBG, D_DBG} state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    state_t     state_q, state_d, arb;
    logic       last_gnt_q, last_gnt_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       cpu_r, dbg_r, cpu_side, dbg_side;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wcnt_d     = wcnt_q;
        // the port finishing in D is masked so a held request is not served twice in a row
        cpu_r      = CpuReq && state_q != D_CPU;
        dbg_r      = DbgReq && state_q != D_DBG;
        arb        = (cpu_r && dbg_r) ? (last_gnt_q ? G_CPU : G_DBG) :
                     cpu_r ? G_CPU : dbg_r ? G_DBG : IDLE;
        cpu_side   = state_q inside {G_CPU, W_CPU, D_CPU};
        dbg_side   = state_q inside {G_DBG, W_DBG, D_DBG};
        MemAdr     = cpu_side ? CpuAdr : dbg_side ? DbgAdr : '0;
        MemWD      = cpu_side ? CpuWD : dbg_side ? DbgWD : '0;
        MemWE      = (state_q == G_CPU && CpuWE) || (state_q == G_DBG && DbgWE);
        CpuReady   = state_q == D_CPU;
        DbgAck     = state_q == D_DBG;
        CpuRD      = CpuReady ? MemRD : '0;
        DbgRD      = DbgAck ? MemRD : '0;
        Busy       = state_q != IDLE;
        case (state_q)
            IDLE, D_CPU, D_DBG: state_d = arb;
            G_CPU: begin
                last_gnt_d = 1'b0;
                wcnt_d     = WAIT_C;
                state_d    = WAIT_C != 4'd0 ? W_CPU : D_CPU;
            end
            G_DBG: begin
                last_gnt_d = 1'b1;
                wcnt_d     = WAIT_C;
                state_d    = WAIT_C != 4'd0 ? W_DBG : D_DBG;
            end
            W_CPU: begin
                wcnt_d  = wcnt_q - 4'd1;
                state_d = wcnt_q == 4'd1 ? D_CPU : W_CPU;
            end
            W_DBG: begin
                wcnt_d  = wcnt_q - 4'd1;
                state_d = wcnt_q == 4'd1 ? D_DBG : W_DBG;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            wcnt_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wcnt_q     <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter with WAIT=0 and WAIT=3 instances.
module tb_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1, init = 1'b1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [31:0] c_adr = 0, c_wd = 0, d_adr = 0, d_wd = 0;
    logic [31:0] c_rd, d_rd, m_adr, m_wd, m_rd;
    logic        c_rdy, d_ack, m_we, busy;
    logic        c3_req = 0, c3_we = 0, d3_req = 0, d3_we = 0;
    logic [31:0] c3_adr = 0, c3_wd = 0, d3_adr = 0, d3_wd = 0;
    logic [31:0] c3_rd, d3_rd, m3_adr, m3_wd, m3_rd;
    logic        c3_rdy, d3_ack, m3_we, busy3;
    logic [31:0] mem0 [64];
    logic [31:0] mem3 [64];
    logic [31:0] ref_mem [64];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DW(32), .AW(32), .WAIT(0)) u0 (
        .clk(clk), .reset(rst),
        .CpuReq(c_req), .CpuWE(c_we), .CpuAdr(c_adr), .CpuWD(c_wd), .CpuRD(c_rd), .CpuReady(c_rdy),
        .DbgReq(d_req), .DbgWE(d_we), .DbgAdr(d_adr), .DbgWD(d_wd), .DbgRD(d_rd), .DbgAck(d_ack),
        .MemAdr(m_adr), .MemWE(m_we), .MemWD(m_wd), .MemRD(m_rd), .Busy(busy));

    mem_arbiter #(.DW(32), .AW(32), .WAIT(3)) u3 (
        .clk(clk), .reset(rst),
        .CpuReq(c3_req), .CpuWE(c3_we), .CpuAdr(c3_adr), .CpuWD(c3_wd), .CpuRD(c3_rd), .CpuReady(c3_rdy),
        .DbgReq(d3_req), .DbgWE(d3_we), .DbgAdr(d3_adr), .DbgWD(d3_wd), .DbgRD(d3_rd), .DbgAck(d3_ack),
        .MemAdr(m3_adr), .MemWE(m3_we), .MemWD(m3_wd), .MemRD(m3_rd), .Busy(busy3));

    function automatic logic [31:0] init_val(int i);
        return i == 2 ? 32'hE280_2005 : 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= init_val(i);
                mem3[i] <= init_val(i);
            end
        end else begin
            if (m_we) mem0[m_adr[7:2]] <= m_wd;
            if (m3_we) mem3[m3_adr[7:2]] <= m3_wd;
        end
        m_rd  <= mem0[m_adr[7:2]];
        m3_rd <= mem3[m3_adr[7:2]];
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int  rem;
        bit  own, last, exp_c, exp_d;
        tick();
        init = 1'b0;
        tick();
        chk("rst_adr", m_adr, 0);
        chk("rst_we", m_we, 0);
        chk("rst_wd", m_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", c_rdy, 0);
        chk("rst_ack", d_ack, 0);
        chk("rst_crd", c_rd, 0);
        chk("rst_drd", d_rd, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_busy3", busy3, 0);
        // CPU read of preloaded word
        c_req = 1; c_we = 0; c_adr = 32'h8;
        tick();
        chk("rd_g_adr", m_adr, 32'h8);
        chk("rd_g_rdy", c_rdy, 0);
        chk("rd_g_busy", busy, 1);
        tick();
        chk("rd_d_rdy", c_rdy, 1);
        chk("rd_d_data", c_rd, 32'hE280_2005);
        chk("rd_d_we", m_we, 0);
        c_req = 0;
        tick();
        chk("rd_after_busy", busy, 0);
        chk("rd_after_rdy", c_rdy, 0);
        // debug write then CPU readback
        d_req = 1; d_we = 1; d_adr = 32'h3C; d_wd = 32'h7;
        tick();
        chk("wr_g_we", m_we, 1);
        chk("wr_g_adr", m_adr, 32'h3C);
        chk("wr_g_wd", m_wd, 32'h7);
        chk("wr_g_ack", d_ack, 0);
        tick();
        chk("wr_d_we", m_we, 0);
        chk("wr_d_ack", d_ack, 1);
        d_req = 0; d_we = 0;
        tick();
        c_req = 1; c_adr = 32'h3C;
        tick();
        tick();
        chk("wr_rb_rdy", c_rdy, 1);
        chk("wr_rb_data", c_rd, 32'h7);
        c_req = 0;
        tick();
        // both held continuously: alternate CPU first, no idle cycles
        pulse_reset();
        c_req = 1; c_adr = 32'h10; d_req = 1; d_we = 0; d_adr = 32'h20;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("alt_busy", busy, 1);
            chk("alt_cpu", c_rdy, (i % 2 == 0) && ((i / 2) % 2 == 1));
            chk("alt_dbg", d_ack, (i % 2 == 0) && ((i / 2) % 2 == 0));
            if (c_rdy) chk("alt_cdata", c_rd, init_val(4));
            if (d_ack) chk("alt_ddata", d_rd, init_val(8));
        end
        c_req = 0; d_req = 0;
        tick();
        tick();
        // held CPU write is not re-granted out of D
        pulse_reset();
        c_req = 1; c_we = 1; c_adr = 32'h40; c_wd = 32'h1234;
        tick();
        chk("hold_g_we", m_we, 1);
        tick();
        chk("hold_d_rdy", c_rdy, 1);
        chk("hold_d_we", m_we, 0);
        tick();
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_we", m_we, 0);
        tick();
        chk("hold_regrant_we", m_we, 1);
        chk("hold_regrant_adr", m_adr, 32'h40);
        c_req = 0; c_we = 0;
        tick();
        tick();
        // randomized traffic against a slot-based model: each grant owns the memory for 2 cycles
        pulse_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem0[i];
        rem = 0; own = 0; last = 1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp_c = rem == 1 && !own;
            exp_d = rem == 1 && own;
            chk("rnd_busy", busy, rem > 0);
            chk("rnd_cpu_ack", c_rdy, exp_c);
            chk("rnd_dbg_ack", d_ack, exp_d);
            if (rem > 0) begin
                chk("rnd_adr", m_adr, own ? d_adr : c_adr);
                chk("rnd_we", m_we, rem == 2 && (own ? d_we : c_we));
                if (rem == 2 && (own ? d_we : c_we)) chk("rnd_wd", m_wd, own ? d_wd : c_wd);
            end else begin
                chk("rnd_idle_we", m_we, 0);
            end
            if (exp_c) begin
                if (c_we) ref_mem[c_adr[7:2]] = c_wd;
                else chk("rnd_cpu_rd", c_rd, ref_mem[c_adr[7:2]]);
                c_req = 0;
            end else if (!c_req && $urandom_range(0, 3) == 0) begin
                c_req = 1; c_we = 1'($urandom_range(0, 1));
                c_adr = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; c_wd = $urandom;
            end
            if (exp_d) begin
                if (d_we) ref_mem[d_adr[7:2]] = d_wd;
                else chk("rnd_dbg_rd", d_rd, ref_mem[d_adr[7:2]]);
                d_req = 0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_adr = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; d_wd = $urandom;
            end
            @(posedge clk);
            if (rem > 0) rem--;
            if (rem == 0 && (c_req || d_req)) begin
                own  = (c_req && d_req) ? !last : d_req;
                last = own;
                rem  = 2;
            end
            @(negedge clk);
        end
        c_req = 0; d_req = 0;
        pulse_reset();
        // WAIT=3 read: G + 3 W + D with stable address
        c3_req = 1; c3_we = 0; c3_adr = 32'h14;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("w3_adr", m3_adr, 32'h14);
            chk("w3_we", m3_we, 0);
            chk("w3_rdy", c3_rdy, i == 5);
            if (i == 5) chk("w3_data", c3_rd, init_val(5));
        end
        c3_req = 0;
        tick();
        chk("w3_idle", busy3, 0);
        // reset during W_DBG, CPU pending across reset
        d3_req = 1; d3_we = 1; d3_adr = 32'h18; d3_wd = 32'hDEAD;
        tick();
        chk("rw_g_we", m3_we, 1);
        tick();
        chk("rw_w_we", m3_we, 0);
        chk("rw_w_busy", busy3, 1);
        rst = 1; c3_req = 1; c3_adr = 32'h1C;
        tick();
        chk("rw_busy", busy3, 0);
        chk("rw_ack", d3_ack, 0);
        chk("rw_adr", m3_adr, 0);
        chk("rw_we", m3_we, 0);
        chk("rw_wd", m3_wd, 0);
        chk("rw_rdy", c3_rdy, 0);
        chk("rw_crd", c3_rd, 0);
        chk("rw_drd", d3_rd, 0);
        rst = 0; d3_req = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("rw_cpu_adr", m3_adr, 32'h1C);
            chk("rw_no_dack", d3_ack, 0);
            chk("rw_cpu_rdy", c3_rdy, i == 5);
        end
        c3_req = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port, synchronous-read unified memory between two requesters: the multicycle CPU datapath (instruction fetch and load/store) and a debug/loader port used to preload and inspect memory.
- Sits between the CPU's Adr/WriteData/MemWrite path and the memory.
- The CPU controller treats CpuReady as a stall qualifier and holds its FSM state until it sees CpuReady.

Parameters:
- DW, 32, data width in bits.
- AW, 32, address width in bits.
- WAIT, 0, extra memory wait cycles inserted between grant and data cycle (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- CpuReq  input  1  CPU access request; held high with stable address/data until CpuReady.
- CpuWE  input  1  CPU write enable (1 = write).
- CpuAdr  input  AW  CPU byte address.
- CpuWD  input  DW  CPU write data.
- CpuRD  output  DW  CPU read data; valid only while CpuReady=1.
- CpuReady  output  1  one-cycle completion pulse for the CPU access.
- DbgReq  input  1  debug access request; same holding rule as CpuReq.
- DbgWE  input  1  debug write enable.
- DbgAdr  input  AW  debug address.
- DbgWD  input  DW  debug write data.
- DbgRD  output  DW  debug read data; valid only while DbgAck=1.
- DbgAck  output  1  one-cycle completion pulse for the debug access.
- MemAdr  output  AW  memory address.
- MemWE  output  1  memory write strobe.
- MemWD  output  DW  memory write data.
- MemRD  input  DW  memory read data; valid one cycle after MemAdr is sampled.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, G_CPU, W_CPU, D_CPU, G_DBG, W_DBG, D_DBG.
- Fairness state: 1-bit LastGnt (0=CPU, 1=DBG) and a 4-bit wait counter WCnt.
- Reset: state=IDLE, LastGnt=1 (CPU wins the first tie), WCnt=0.
- Outputs in IDLE and after reset: all 0 (MemAdr=0, MemWD=0, MemWE=0, CpuReady=0, DbgAck=0, CpuRD=0, DbgRD=0, Busy=0).
- Arbitration applies in IDLE and in any D_x state:
  - Only one request high: grant that requester.
  - Both high: grant the requester that is not LastGnt.
  - Neither high: go to IDLE.
- In D_x, the finishing requester's request is treated as 0 for that decision, so a held request is not double-served.
- The next state of the arbitration is G_x, giving back-to-back accesses with no IDLE bubble.
- G_x (1 cycle):
  - MemAdr/MemWD driven from the granted port.
  - MemWE = granted port's WE.
  - LastGnt updated to x.
  - WCnt loaded with WAIT.
  - Next state: W_x if WAIT>0, else D_x.
- W_x:
  - MemAdr and MemWD stay on the granted port; MemWE=0.
  - WCnt decrements each cycle; go to D_x when WCnt==1.
- D_x (1 cycle):
  - MemAdr stays on the granted port; MemWE=0.
  - The x ack (CpuReady or DbgAck) is 1.
  - x read data = MemRD combinationally; the other port's read data = 0.
  - Writes also receive the ack; read data is don't-care for a write.
- Latency from request sampled in IDLE: ack in cycle 2+WAIT after the sampling edge. A request sampled at edge n is acked in the cycle after edge n+1+WAIT.
- Each write produces exactly one MemWE pulse.
- A request dropped before its ack: the access still completes and the ack still fires. The requester ignores that ack.
- A requester that changes address mid-access: undefined result; no protection is provided.
- Reset mid-access: the next edge returns to IDLE and no ack is issued. A write whose G cycle has already passed stays committed.
- Address wrap: addresses are passed through unmodified; no alignment check.

Test Plan:
- Reset, then CpuReq=1, CpuWE=0, CpuAdr=0x8, memory holds 0xE2802005 at 0x8, WAIT=0 -> MemAdr=0x8 in G_CPU; CpuReady=1 with CpuRD=0xE2802005 exactly 2 cycles after the request edge; Busy low afterwards.
- DbgReq write, DbgAdr=0x3C, DbgWD=0x0000_0007 -> exactly one MemWE pulse with MemAdr=0x3C, MemWD=7; DbgAck one cycle later. A subsequent CPU read of 0x3C returns 7.
- CpuReq and DbgReq both held high continuously for 8 accesses -> grants alternate CPU, DBG, CPU, …, starting with CPU after reset. No IDLE cycles between accesses; no requester is served twice in a row.
- WAIT=3, CPU read -> stays in G for 1 cycle and W for 3 cycles; CpuReady appears 5 cycles after the request edge with MemAdr stable throughout; MemWE=0 in W/D.
- Reset asserted during W_DBG -> next cycle IDLE, DbgAck never pulses, all outputs 0. A pending CpuReq is granted first after reset release.
- CPU write, then CpuReq held through D_CPU with DbgReq low -> the same request is not re-granted in the cycle of D_CPU. It is re-granted only if still high one cycle later in IDLE.
